ads8684_scan_ctrl: RTL
======================

// Module: ads8684_scan_ctrl
// PURPOSE
//  SPI master and scan sequencer for one ADS8684 4-channel ADC.
//  - On a trigger, converts each channel enabled in a latched mask, in ascending order.
//  - Handles the one-frame command-to-data pipeline of the ADC.
//  - Returns one 16-bit result per enabled channel, tagged with the channel index, to
//    the downstream acquisition logic.
// PARAMETERS
//  SCLK_DIV  4  clk cycles per sclk half-period (>=2)
//  CSN_HIGH  3  clk cycles csn_o held high between frames (>=1)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  trig_i        in   1   start-scan pulse; sampled only in IDLE
//  chan_mask_i   in   4   bit n enables channel n; latched on accepted trigger
//  busy_o        out  1   high from accepted trigger until return to IDLE
//  overrun_o     out  1   1-cycle pulse: trig_i high while busy_o high
//  csn_o         out  1   ADC chip select, active low
//  sclk_o        out  1   ADC serial clock, idle low
//  sdi_o         out  1   ADC command data, MSB first
//  sdo_i         in   1   ADC read data
//  data_o        out  16  last conversion result
//  data_ch_o     out  2   channel index of data_o
//  data_valid_o  out  1   1-cycle strobe qualifying data_o/data_ch_o
// BEHAVIOUR
//  Reset values: csn_o=1, sclk_o=0, sdi_o=0, busy_o=0, overrun_o=0, data_o=0,
//  data_ch_o=0, data_valid_o=0. FSM enters IDLE.
//  Reset mid-frame: csn_o and sclk_o return to idle at once. The scan is dropped and no
//  data_valid_o is produced.
//  FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP, then LEAD (more frames) or IDLE.
//   IDLE:
//    - trig_i=1 with mask!=0 latches mask, sets busy_o, goes to LEAD.
//    - trig_i=1 with mask==0 is ignored: no bus activity, busy_o stays 0.
//   LEAD: csn_o=0; sdi_o = bit 31 of the frame word; hold SCLK_DIV cycles.
//   SHIFT: 32 sclk periods, each SCLK_DIV cycles low then SCLK_DIV cycles high.
//    - sdi_o changes only while sclk_o is low: next bit at each falling edge.
//    - sdo_i is sampled in the clk cycle where sclk_o goes 0->1.
//    - The sampled bit shifts into a 32-bit rx register, MSB first.
//   TRAIL: sclk_o=0, csn_o=0 for SCLK_DIV cycles; then csn_o=1.
//   GAP: csn_o=1 for CSN_HIGH cycles.
//  Frame words, N = popcount(mask), N+1 frames per scan:
//   - Frames 0..N-1: {cmd,16'h0000}, where cmd = 16'hC000 | (ch<<10) for the k-th
//     enabled channel (ch0 C000, ch1 C400, ch2 C800, ch3 CC00).
//   - Frame N: 32'h0000_0000 (no-op).
//  Result pipeline:
//   - rx[15:0] of frame k (k>=1) is the result for the channel commanded in frame k-1.
//   - Frame 0 rx data is discarded.
//   - data_valid_o pulses the cycle after csn_o rises at the end of frame k>=1.
//   - data_o and data_ch_o hold their value until the next strobe.
//  Frame length: 2*SCLK_DIV*32 + 2*SCLK_DIV clk cycles with csn_o low.
//  Scan end: after frame N's result strobe and its GAP, FSM returns to IDLE and busy_o
//  falls. The earliest new trigger is accepted the next cycle.
//  Mask changes while busy have no effect on the running scan.
//  overrun_o: trig_i=1 in any non-IDLE state pulses overrun_o and is otherwise ignored.
// TESTING
//  (bench uses ads8684_model on csn/sclk/sdi/sdo; SCLK_DIV=4, CSN_HIGH=3)
//  1 mask=0001, ain_0p=CAFE, trig -> 2 frames, sdi words C0000000,00000000;
//    one strobe data_o=CAFE, data_ch_o=0; busy_o drops after 2nd GAP.
//  2 mask=1010, ain_1p=1234, ain_3p=BEEF -> sdi C4000000,CC000000,00000000;
//    strobes (1,1234) then (3,BEEF), none else.
//  3 mask=1111, distinct ain values -> 5 frames, 4 strobes in ch order 0,1,2,3 with
//    matching data; csn_o high >=CSN_HIGH cycles between frames.
//  4 mask=0000, trig -> csn_o stays 1, sclk_o 0, busy_o 0, no strobe.
//  5 trig again 10 cycles into scan -> overrun_o one pulse; scan completes unchanged.
//  6 rst_n low during frame 0 SHIFT at bit 20 -> csn_o=1, sclk_o=0 at once, no strobe.
//    After release, mask=0001 scan returns CAFE (not the model's FFFF).

Source files
------------

// File: rtl/ads8684_scan_ctrl.sv
// SPI master and scan sequencer for one ADS8684: commands each enabled channel in
// ascending order, then a trailing no-op frame to flush the ADC's one-frame pipeline.
module ads8684_scan_ctrl #(
    parameter int SCLK_DIV = 4,
    parameter int CSN_HIGH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig_i,
    input  logic [3:0]  chan_mask_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        csn_o,
    output logic        sclk_o,
    output logic        sdi_o,
    input  logic        sdo_i,
    output logic [15:0] data_o,
    output logic [1:0]  data_ch_o,
    output logic        data_valid_o
);
    localparam int CMAX = (SCLK_DIV > CSN_HIGH) ? SCLK_DIV : CSN_HIGH;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HALF_END = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(CSN_HIGH - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [3:0]    pend_q, pend_d;
    logic [31:0]   tx_q, tx_d;
    // Only the low half of each received word carries the result, and after 32
    // shifts a 16-bit register holds exactly those bits.
    logic [15:0]   rx_q, rx_d;
    logic [1:0]    cmd_ch_q, cmd_ch_d, prev_ch_q, prev_ch_d;
    logic          have_prev_q, have_prev_d, noop_q, noop_d;
    logic          csn_q, csn_d, sclk_q, sclk_d, sdi_q, sdi_d;
    logic          busy_q, busy_d, ovr_q, ovr_d, dv_q, dv_d;
    logic [15:0]   data_q, data_d;
    logic [1:0]    data_ch_q, data_ch_d;

    logic [3:0]    src;
    logic [1:0]    nxt_ch;
    logic [31:0]   nxt_word;
    logic          start;

    // Next frame comes from the lowest still-pending channel; none left means no-op.
    always_comb begin
        src    = (state_q == IDLE) ? chan_mask_i : pend_q;
        nxt_ch = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (src[i]) nxt_ch = 2'(i);
        nxt_word = (src != 4'b0) ? {16'hC000 | (16'(nxt_ch) << 10), 16'h0000} : 32'h0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        pend_d      = pend_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cmd_ch_d    = cmd_ch_q;
        prev_ch_d   = prev_ch_q;
        have_prev_d = have_prev_q;
        noop_d      = noop_q;
        csn_d       = csn_q;
        sclk_d      = sclk_q;
        sdi_d       = sdi_q;
        busy_d      = busy_q;
        data_d      = data_q;
        data_ch_d   = data_ch_q;
        dv_d        = 1'b0;
        ovr_d       = trig_i && (state_q != IDLE);
        start       = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_i && chan_mask_i != 4'b0) begin
                    start  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            LEAD: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = 5'd0;
                    state_d = SHIFT;
                end else cnt_d = cnt_q + 1'b1;
            end
            SHIFT: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[14:0], sdo_i};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 5'd31) state_d = TRAIL;
                        else begin
                            bit_d = bit_q + 5'd1;
                            tx_d  = {tx_q[30:0], 1'b0};
                            sdi_d = tx_q[30];
                        end
                    end
                end else cnt_d = cnt_q + 1'b1;
            end
            TRAIL: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    sdi_d   = 1'b0;
                    state_d = GAP;
                end else cnt_d = cnt_q + 1'b1;
            end
            GAP: begin
                // Data read in this frame answers the command of the previous frame.
                if (cnt_q == '0 && have_prev_q) begin
                    dv_d      = 1'b1;
                    data_d    = rx_q;
                    data_ch_d = prev_ch_q;
                end
                if (cnt_q == GAP_END) begin
                    if (noop_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else start = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d     = LEAD;
            cnt_d       = '0;
            csn_d       = 1'b0;
            sclk_d      = 1'b0;
            tx_d        = nxt_word;
            sdi_d       = nxt_word[31];
            pend_d      = src & ~(4'b0001 << nxt_ch);
            noop_d      = (src == 4'b0);
            prev_ch_d   = cmd_ch_q;
            cmd_ch_d    = nxt_ch;
            have_prev_d = (state_q != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 5'd0;
            pend_q      <= 4'b0;
            tx_q        <= 32'h0;
            rx_q        <= 16'h0;
            cmd_ch_q    <= 2'd0;
            prev_ch_q   <= 2'd0;
            have_prev_q <= 1'b0;
            noop_q      <= 1'b0;
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            sdi_q       <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            dv_q        <= 1'b0;
            data_q      <= 16'h0;
            data_ch_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            pend_q      <= pend_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cmd_ch_q    <= cmd_ch_d;
            prev_ch_q   <= prev_ch_d;
            have_prev_q <= have_prev_d;
            noop_q      <= noop_d;
            csn_q       <= csn_d;
            sclk_q      <= sclk_d;
            sdi_q       <= sdi_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            dv_q        <= dv_d;
            data_q      <= data_d;
            data_ch_q   <= data_ch_d;
        end
    end

    assign busy_o       = busy_q;
    assign overrun_o    = ovr_q;
    assign csn_o        = csn_q;
    assign sclk_o       = sclk_q;
    assign sdi_o        = sdi_q;
    assign data_o       = data_q;
    assign data_ch_o    = data_ch_q;
    assign data_valid_o = dv_q;
endmodule
